dcache_controller: RTL

Direct-mapped, write-back, write-allocate data cache between the MEM stage and a 256-bit-line external memory. Serves loads and stores on hit with zero stall cycles. On miss it raises `cpu_stall_o`, which drives the `mem_stall_i` freeze input of every pipeline register, and holds it until the line is refilled. It owns the memory-side request/acknowledge handshake, including write-back of dirty victims.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/dcache_sram.sv | 60 ++++++
 rtl/dcache_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types, line geometry and address field helpers for the data cache.
package cache_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    // Tag field, right-justified; callers cast to their tag width.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

    // Set index field, right-justified; callers cast to their index width.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
        return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Word within the line; word 0 sits in line bits [31:0].
    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage for a direct-mapped cache.
// Combinational read of one set; writes are either a whole-line refill
// or a single-word store that also marks the set dirty.
module dcache_sram
    import cache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 23
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  i_idx,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_line,
    input  logic              i_line_we,
    input  logic [TAG_W-1:0]  i_line_tag,
    input  logic [LINE_W-1:0] i_line_data,
    input  logic              i_word_we,
    input  logic [2:0]        i_word_sel,
    input  logic [WORD_W-1:0] i_word_data
);

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    // Status bits: cleared asynchronously, set by refill / store.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_line_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (i_line_we) begin
            r_tag[i_idx]  <= i_line_tag;
            r_data[i_idx] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_idx][{i_word_sel, 5'd0} +: WORD_W] <= i_word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache controller.
// Zero-stall hits; misses stall the pipeline while a dirty victim is
// written back and the requested line is fetched.
module dcache_controller
    import cache_pkg::*;
#(
    parameter int SETS = 16
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 27 - IDX_W;

    state_t r_state;
    state_t w_state_next;

    logic [TAG_W-1:0]  w_req_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [2:0]        w_word;
    logic              w_vic_valid;
    logic              w_vic_dirty;
    logic [TAG_W-1:0]  w_vic_tag;
    logic [LINE_W-1:0] w_line;
    logic              w_hit;
    logic              w_line_we;
    logic              w_word_we;

    assign w_req_tag = TAG_W'(addr_tag(cpu_addr_i, IDX_W));
    assign w_idx     = IDX_W'(addr_index(cpu_addr_i, IDX_W));
    assign w_word    = addr_word(cpu_addr_i);

    assign w_hit     = cpu_req_i & w_vic_valid & (w_vic_tag == w_req_tag);
    // Refill completes on the ack; store hits merge only when not stalled.
    assign w_line_we = (r_state == REFILL) & mem_ack_i;
    assign w_word_we = (r_state == IDLE) & w_hit & cpu_write_i & ~rst_i;

    dcache_sram #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_idx       (w_idx),
        .o_valid     (w_vic_valid),
        .o_dirty     (w_vic_dirty),
        .o_tag       (w_vic_tag),
        .o_line      (w_line),
        .i_line_we   (w_line_we),
        .i_line_tag  (w_req_tag),
        .i_line_data (mem_data_i),
        .i_word_we   (w_word_we),
        .i_word_sel  (w_word),
        .i_word_data (cpu_data_i)
    );

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus Moore memory-port decode and CPU-side outputs.
    always_comb begin
        w_state_next = r_state;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (r_state)
            IDLE: begin
                cpu_stall_o = cpu_req_i & ~w_hit;
                if (cpu_req_i && !w_hit) begin
                    w_state_next = (w_vic_valid && w_vic_dirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {w_vic_tag, w_idx, 5'd0};
                mem_data_o   = w_line;
                if (mem_ack_i) begin
                    w_state_next = REFILL;
                end
            end
            REFILL: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_req_tag, w_idx, 5'd0};
                if (mem_ack_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // The pipeline must never be frozen while reset is held.
        if (rst_i) begin
            cpu_stall_o = 1'b0;
        end
        if (cpu_req_i && !cpu_write_i && !cpu_stall_o && (r_state == IDLE)) begin
            cpu_data_o = w_line[{w_word, 5'd0} +: 32];
        end
    end

endmodule
